// File: rtl/preset_entry_scan_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// preset_entry_scan_pkg : shared state encoding, display codes, 7-seg patterns
// Revision: 1.0
// ----------------------------------------------------------------------------
package preset_entry_scan_pkg;

  typedef enum logic [0:0] {
    EDIT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  localparam logic [6:0] SEG_MINUS = 7'h40;

  // Segment order gfedcba, active-high.
  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/preset_entry_scan_seg7_decode.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_decode : 4-bit display code to active-high segments (dp always off)
// Revision: 1.0
// ----------------------------------------------------------------------------
module seg7_decode
  import preset_entry_scan_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] light
);

  always_comb begin
    light = 8'h00;
    if (code == CODE_MINUS) begin
      light = {1'b0, SEG_MINUS};
    end else if (code <= 4'd9) begin
      light = {1'b0, seg_pattern(code)};
    end
  end

endmodule
`default_nettype wire

// File: rtl/preset_entry_scan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// preset_entry_scan : multi-digit preset editor with auto-repeat, scanned
//                     7-segment display and valid/ready hand-off
// Revision: 1.0
// ----------------------------------------------------------------------------
module preset_entry_scan
  import preset_entry_scan_pkg::*;
#(
  parameter int NDIG       = 3,
  parameter int REPEAT_CYC = 66000000,
  parameter int SCAN_CYC   = 100000,
  parameter int ALLOW_NEG  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   btn_dig,
  input  logic              down,
  input  logic              sign,
  input  logic              next,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [4*NDIG-1:0] out_digits,
  output logic              out_neg,
  output logic              is_on,
  output logic [7:0]        light,
  output logic [NDIG:0]     ena
);

  localparam int SLOT_W = $clog2(NDIG + 1);
  localparam int TMR_W  = $clog2(REPEAT_CYC + 1);
  localparam int SCAN_W = $clog2(SCAN_CYC + 1);
  localparam logic [NDIG:0] ENA_RST = {{NDIG{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NDIG-1:0]     r_btn_q;
  logic                r_sign_q;
  logic                r_next_q;
  logic                r_neg;
  logic [SLOT_W-1:0]   r_slot;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [4*NDIG-1:0]   w_digits;
  logic                w_edit;
  logic                w_confirm;
  logic [3:0]          w_code;
  logic [7:0]          w_light;

  assign w_edit = (r_state == EDIT);

  // A refused confirm edge is simply lost: r_next_q still follows the input.
  assign w_confirm = w_edit && next && !r_next_q && (btn_dig == '0) && !sign
                     && ((ALLOW_NEG != 0) || !r_neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EDIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EDIT:    if (w_confirm) w_state_nxt = LOCK;
      LOCK:    if (out_ready) w_state_nxt = EDIT;
      default: w_state_nxt = EDIT;
    endcase
  end

  assign out_valid = (r_state == LOCK);
  assign is_on     = w_edit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q  <= '0;
      r_sign_q <= 1'b0;
      r_next_q <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      r_btn_q  <= btn_dig;
      r_sign_q <= sign;
      r_next_q <= next;
      if (w_edit && sign && !r_sign_q) r_neg <= ~r_neg;
    end
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_digit
    logic [3:0]       r_dig;
    logic [TMR_W-1:0] r_tmr;
    logic             w_step;

    // Timer 0 means idle: a button still held when LOCK ends never repeats
    // until it is released and pressed again.
    assign w_step = w_edit && btn_dig[i]
                    && (!r_btn_q[i] || (r_tmr == TMR_W'(REPEAT_CYC)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dig <= 4'd0;
        r_tmr <= '0;
      end else begin
        if (w_step) begin
          if (down) r_dig <= (r_dig == 4'd0) ? 4'd9 : r_dig - 4'd1;
          else      r_dig <= (r_dig == 4'd9) ? 4'd0 : r_dig + 4'd1;
        end
        if (!w_edit || !btn_dig[i]) r_tmr <= '0;
        else if (w_step)            r_tmr <= TMR_W'(1);
        else if (r_tmr != '0)       r_tmr <= r_tmr + 1'b1;
      end
    end

    assign w_digits[4*i +: 4] = r_dig;
  end

  assign out_digits = w_digits;
  assign out_neg    = r_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_slot     <= '0;
    end else if (r_scan_cnt == SCAN_W'(SCAN_CYC - 1)) begin
      r_scan_cnt <= '0;
      r_slot     <= (r_slot == SLOT_W'(NDIG)) ? '0 : r_slot + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_comb begin
    w_code = r_neg ? CODE_MINUS : CODE_BLANK;
    for (int i = 0; i < NDIG; i++) begin
      if (r_slot == SLOT_W'(i)) w_code = w_digits[4*i +: 4];
    end
  end

  seg7_decode u_seg7_decode (
    .code  (w_code),
    .light (w_light)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light <= {1'b0, seg_pattern(4'd0)};
      ena   <= ENA_RST;
    end else begin
      light <= w_light;
      ena   <= ENA_RST << r_slot;
    end
  end

endmodule
`default_nettype wire
